// File: rtl/ofmap_wr_addr_gen_if.sv
// Signal bundle between the systolic-array result port, the ofmap SRAM write
// port and the top-level sequencer, as seen by ofmap_wr_addr_gen.
// slave  : the address generator itself
// master : whatever drives it (top FSM, array, SRAM arbiter or a bench)
interface ofmap_wr_addr_gen_if #(
    parameter int SRAM_ADDR_W = 16,
    parameter int DATA_W      = 32
);
    logic                   start_i;
    logic [SRAM_ADDR_W-1:0] base_addr_i;
    logic                   res_valid_i;
    logic [DATA_W-1:0]      res_data_i;
    logic                   res_last_i;
    logic                   res_ready_o;
    logic                   sram_wr_en_o;
    logic [SRAM_ADDR_W-1:0] sram_wr_addr_o;
    logic [DATA_W-1:0]      sram_wr_data_o;
    logic                   sram_gnt_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;

    modport slave (
        input  start_i, base_addr_i, res_valid_i, res_data_i, res_last_i, sram_gnt_i,
        output res_ready_o, sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, base_addr_i, res_valid_i, res_data_i, res_last_i, sram_gnt_i,
        input  res_ready_o, sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/ofmap_wr_addr_gen.sv
// Output-feature-map write address generator.
// Takes the Conv2D result stream, writes each pixel to ofmap SRAM in raster
// order at base + h*OUT_W + w, using only incrementers (no multiplier).
// A single write register decouples the result stream from SRAM grants and
// still sustains one beat per cycle when the SRAM grants every cycle.
//
// Build option: OFMAP_RELU_EN -- clamp negative results to zero as they are
// loaded into the write register (no extra latency).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start_i; no image in flight
// ST_RUN   | accepting result beats and issuing writes
// ST_FLUSH | all beats accepted; waiting for the final write to be granted
module ofmap_wr_addr_gen #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int K_R         = 5,
    parameter int K_S         = 5,
    parameter int SRAM_ADDR_W = 16,
    parameter int DATA_W      = 32
) (
    input  logic               clk_i,
    input  logic               rst_sync_n_i,
    ofmap_wr_addr_gen_if.slave bus
);
    localparam int OUT_W = IMG_W - K_S + 1;
    localparam int OUT_H = IMG_H - K_R + 1;

    localparam logic [7:0]             W_LAST   = 8'(OUT_W - 1);
    localparam logic [7:0]             H_LAST   = 8'(OUT_H - 1);
    localparam logic [SRAM_ADDR_W-1:0] ROW_STEP = SRAM_ADDR_W'(OUT_W);
    localparam logic [SRAM_ADDR_W-1:0] ADDR_ONE = SRAM_ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             w_q, w_d;
    logic [7:0]             h_q, h_d;
    logic [SRAM_ADDR_W-1:0] row_base_q, row_base_d;
    logic [SRAM_ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [SRAM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   pending_q, pending_d;
    logic                   err_q, err_d;

    logic                   ready;
    logic                   accept;
    logic                   retire;
    logic                   done;
    logic                   last_beat;
    logic [DATA_W-1:0]      load_data;

    // Value placed in the write register for an accepted beat.
    always_comb begin
        load_data = bus.res_data_i;
`ifdef OFMAP_RELU_EN
        if (bus.res_data_i[DATA_W-1]) begin
            load_data = '0;
        end
`endif
    end

    // Next-state, handshake and address-walk logic.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        row_base_d  = row_base_q;
        next_addr_d = next_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pending_d   = pending_q;
        err_d       = err_q;
        ready       = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        retire      = pending_q && bus.sram_gnt_i;
        last_beat   = (w_q == W_LAST) && (h_q == H_LAST);

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d     = ST_RUN;
                    row_base_d  = bus.base_addr_i;
                    next_addr_d = bus.base_addr_i;
                    w_d         = '0;
                    h_d         = '0;
                    err_d       = 1'b0;
                end
            end
            ST_RUN: begin
                // A granted write frees the register in the same cycle,
                // which is what keeps the stream at one beat per cycle.
                ready  = !pending_q || bus.sram_gnt_i;
                accept = ready && bus.res_valid_i;
                if (accept && last_beat) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (retire) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retire) begin
            pending_d = 1'b0;
        end

        if (accept) begin
            pending_d = 1'b1;
            wr_addr_d = next_addr_q;
            wr_data_d = load_data;
            if (bus.res_last_i != last_beat) begin
                err_d = 1'b1;
            end
            if (w_q != W_LAST) begin
                w_d         = w_q + 8'd1;
                next_addr_d = next_addr_q + ADDR_ONE;
            end else begin
                w_d         = '0;
                h_d         = h_q + 8'd1;
                row_base_d  = row_base_q + ROW_STEP;
                next_addr_d = row_base_q + ROW_STEP;
            end
        end
    end

    // State and datapath registers; reset aborts any image in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_sync_n_i) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            h_q         <= '0;
            row_base_q  <= '0;
            next_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            row_base_q  <= row_base_d;
            next_addr_q <= next_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    assign bus.res_ready_o    = ready;
    assign bus.sram_wr_en_o   = pending_q;
    assign bus.sram_wr_addr_o = wr_addr_q;
    assign bus.sram_wr_data_o = wr_data_q;
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.done_o         = done;
    assign bus.err_o          = err_q;
endmodule
